// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide sequential adder front-end.
package wide_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned WORD_W_DEFAULT = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wide_add_seq.sv
// Feeds a combinational word adder one word per cycle (LSW first), chaining
// the carry, and collects the wide sum behind a valid/ready handshake.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEFAULT,
    parameter int unsigned NUM_WORDS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] op_a,
    input  logic [WORD_W*NUM_WORDS-1:0] op_b,
    input  logic                        op_cin,
    output logic [WORD_W-1:0]           add_a,
    output logic [WORD_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [WORD_W-1:0]           add_sum,
    input  logic                        add_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic                        result_cout
);

    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic [WORD_W*NUM_WORDS-1:0] opa_q, opa_d;
    logic [WORD_W*NUM_WORDS-1:0] opb_q, opb_d;
    logic [WORD_W*NUM_WORDS-1:0] res_q, res_d;
    logic                        rcout_q, rcout_d;
    logic [IDX_W-1:0]            sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            rcout_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            rcout_q <= rcout_d;
        end
    end

    // The final carry-out goes to result_cout only, so carry_q (and add_cin)
    // keeps the last word's carry-in while DONE holds the adder inputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        rcout_d = rcout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[int'(idx_q)*WORD_W +: WORD_W] = add_sum;
                if (idx_q == LAST_IDX) begin
                    rcout_d = add_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    carry_d = add_cout;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel = (state_q == ST_DONE) ? LAST_IDX : idx_q;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q != ST_IDLE) begin
            add_a   = opa_q[int'(sel)*WORD_W +: WORD_W];
            add_b   = opb_q[int'(sel)*WORD_W +: WORD_W];
            add_cin = carry_q;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = res_q;
    assign result_cout = rcout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with a behavioural word adder attached.
module tb_wide_add_seq;

    localparam int unsigned WW = 64;
    localparam int unsigned NW = 2;
    localparam int unsigned TW = WW * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] op_a;
    logic [TW-1:0] op_b;
    logic          op_cin;
    logic [WW-1:0] add_a;
    logic [WW-1:0] add_b;
    logic          add_cin;
    logic [WW-1:0] add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] result;
    logic          result_cout;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        cins [NW];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (WW + 1)'(add_cin);

    wide_add_seq #(
        .WORD_W   (WW),
        .NUM_WORDS(NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_cout(result_cout)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] rnd_wide();
        logic [TW-1:0] v;
        for (int unsigned i = 0; i < TW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic do_add(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                          input int unsigned hold, input string tag);
        logic [TW:0] exp;
        int unsigned lat;
        int unsigned nrun;
        exp = {1'b0, a} + {1'b0, b} + (TW + 1)'(cin);
        check({tag, "/in_ready_idle"}, in_ready, 1);
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = rnd_wide();
        op_b     = rnd_wide();
        op_cin   = ~cin;
        lat      = 1;
        nrun     = 0;
        while (!out_valid && lat < 20) begin
            if (nrun < NW) cins[nrun] = add_cin;
            nrun++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, NW + 1);
        check({tag, "/result"}, result, exp[TW-1:0]);
        check({tag, "/cout"}, result_cout, exp[TW]);
        check({tag, "/in_ready_done"}, in_ready, 0);
        if (hold > 0) in_valid = 1'b1;
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, out_valid, 1);
            check({tag, "/hold_result"}, result, exp[TW-1:0]);
            check({tag, "/hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "/release_valid"}, out_valid, 0);
        check({tag, "/release_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        #2;
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/result", result, 0);
        check("reset/cout", result_cout, 0);
        check("reset/add_a", add_a, 0);
        check("reset/add_cin", add_cin, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_add(128'd2, 128'd5, 1'b0, 0, "small");
        do_add(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 0, "xword");
        check("xword/cin_w0", cins[0], 0);
        check("xword/cin_w1", cins[1], 1);
        do_add('1, 128'd1, 1'b0, 0, "ovf");
        do_add(128'd20, 128'd20, 1'b1, 0, "cin");
        check("cin/cin_w0", cins[0], 1);
        do_add(128'd128, 128'd128, 1'b0, 5, "bp");
        check("idle/add_a", add_a, 0);
        check("idle/add_cin", add_cin, 0);

        op_a     = 128'd75;
        op_b     = 128'd75;
        op_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rstrun/out_valid", out_valid, 0);
        check("rstrun/in_ready", in_ready, 1);
        check("rstrun/result", result, 0);
        check("rstrun/cout", result_cout, 0);
        check("rstrun/add_a", add_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_add(128'd200, 128'd20, 1'b0, 0, "after_rst");

        for (int unsigned t = 0; t < 25; t++) begin
            logic [TW-1:0] a;
            logic [TW-1:0] b;
            a = rnd_wide();
            b = ($urandom_range(0, 3) == 0) ? ~a : rnd_wide();
            do_add(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
